// File: rtl/alu_op_sequencer.sv
// Purpose : registers one ALU op (add/sub/mul/div), holds it on the ALU inputs for a per-op latency and captures the result.
// Latency : rsp_valid first high LAT(op) cycles after the request is accepted (ADD_LAT add/sub, MUL_LAT mul, DIV_LAT div).
// Backpres: one op in flight; req_ready is low from accept until the response handshake, and the response holds while rsp_ready is low.
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   req_valid/req_ready          request handshake carrying req_op, req_a, req_b
//   alu_in1/alu_in2/alu_signal   registered operands and op select driven to the combinational ALU
//   alu_result                   ALU output, sampled once the op latency has elapsed
//   rsp_valid/rsp_ready          response handshake carrying rsp_data, rsp_err
//
// Build option ALU_SEQ_DIVZERO_CHECK_EN: a div with req_b==0 bypasses the ALU and returns
// all ones with rsp_err=1 one cycle after accept. Without it rsp_err is tied low.
module alu_op_sequencer #(
    parameter int WIDTH   = 64,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [1:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT)
                                                 : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    generate
        if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
            $error("alu_op_sequencer: every latency parameter must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] lat_sel;
    logic             accept;
    logic             capture;

    // Ready is masked by reset so nothing is accepted on a reset edge.
    assign req_ready = (state == ST_IDLE) && !reset;
    assign rsp_valid = (state == ST_RESP);

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    logic div_zero_req;
    logic div_zero_q;
`endif

    // Latency for the op currently offered on the request port.
    always_comb begin
        case (req_op)
            2'b10:   lat_sel = CNT_W'(MUL_LAT);
            2'b11:   lat_sel = CNT_W'(DIV_LAT);
            default: lat_sel = CNT_W'(ADD_LAT);
        endcase
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        // Divide by zero does not wait for the divider: a one-cycle count
        // lands it in RESP on the edge after accept.
        div_zero_req = (req_op == 2'b11) && (req_b == '0);
        if (div_zero_req) begin
            lat_sel = CNT_W'(1);
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    cnt_nxt   = lat_sel;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    capture   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_signal <= 2'b00;
            rsp_data   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                alu_in1    <= req_a;
                alu_in2    <= req_b;
                alu_signal <= req_op;
            end
            if (capture) begin
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
                rsp_data <= div_zero_q ? {WIDTH{1'b1}} : alu_result;
`else
                rsp_data <= alu_result;
`endif
            end
        end
    end

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            div_zero_q <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                div_zero_q <= div_zero_req;
            end
            if (capture) begin
                rsp_err <= div_zero_q;
            end
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose : directed checks of alu_op_sequencer against hand-computed results, with a behavioural ALU attached.
// Latency : measured per op from the accept edge to the first cycle rsp_valid is seen high.
// Backpres: exercises a held-off response (rsp_ready low) and a request waiting behind it.
module tb_alu_op_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [63:0] alu_in1;
    logic [63:0] alu_in2;
    logic [1:0]  alu_signal;
    logic [63:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DIV0_VALUE = 64'hDEAD_BEEF_0000_0001;

    alu_op_sequencer #(
        .WIDTH  (64),
        .ADD_LAT(1),
        .MUL_LAT(3),
        .DIV_LAT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_signal(alu_signal),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU; divide by zero returns a recognisable marker.
    always_comb begin
        case (alu_signal)
            2'b00:   alu_result = alu_in1 + alu_in2;
            2'b01:   alu_result = alu_in1 - alu_in2;
            2'b10:   alu_result = alu_in1 * alu_in2;
            default: alu_result = (alu_in2 == 64'd0) ? DIV0_VALUE : alu_in1 / alu_in2;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a request once ready, hold it through the accept edge, then withdraw it.
    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        int k = 0;
        while (!req_ready && k < 40) begin
            step();
            k++;
        end
        chk("issue_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
    endtask

    // Count edges from accept until rsp_valid; optionally scramble req_* and
    // confirm the registered ALU inputs do not move.
    task automatic wait_rsp(output int n, input bit scramble,
                            input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
        n = 0;
        while (!rsp_valid && n < 40) begin
            if (scramble) begin
                req_a  = {$urandom, $urandom};
                req_b  = {$urandom, $urandom};
                req_op = 2'($urandom);
            end
            step();
            n++;
            if (scramble) begin
                chk("stable_in1", alu_in1, a);
                chk("stable_in2", alu_in2, b);
                chk("stable_sig", {62'd0, alu_signal}, {62'd0, op});
            end
        end
    endtask

    // Response handshake with rsp_ready high: next cycle is idle and ready.
    task automatic finish_rsp(input string tag);
        step();
        chk({tag, "_vld_drop"}, {63'd0, rsp_valid}, 64'd0);
        chk({tag, "_rdy_back"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        int n;
        int seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        step();
        step();

        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_alu_in1", alu_in1, 64'd0);
        chk("rst_alu_in2", alu_in2, 64'd0);
        chk("rst_alu_sig", {62'd0, alu_signal}, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

        // add 5 + 7
        issue(2'b00, 64'd5, 64'd7);
        chk("add_busy", {63'd0, req_ready}, 64'd0);
        wait_rsp(n, 1'b0, 0, 0, 0);
        chk("add_lat", 64'(n), 64'd1);
        chk("add_data", rsp_data, 64'd12);
        chk("add_err", {63'd0, rsp_err}, 64'd0);
        finish_rsp("add");

        // sub 0 - 1 wraps
        issue(2'b01, 64'd0, 64'd1);
        wait_rsp(n, 1'b0, 0, 0, 0);
        chk("sub_lat", 64'(n), 64'd1);
        chk("sub_data", rsp_data, ALL_ONES);
        finish_rsp("sub");

        // mul 2^40 * 2^30 truncates to zero
        issue(2'b10, 64'd1 << 40, 64'd1 << 30);
        wait_rsp(n, 1'b0, 0, 0, 0);
        chk("mul_lat", 64'(n), 64'd3);
        chk("mul_data", rsp_data, 64'd0);
        finish_rsp("mul");

        // div 100 / 7 with response held off and a request waiting
        rsp_ready = 1'b0;
        issue(2'b11, 64'd100, 64'd7);
        wait_rsp(n, 1'b0, 0, 0, 0);
        chk("div_lat", 64'(n), 64'd8);
        chk("div_data", rsp_data, 64'd14);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 64'd1;
        req_b     = 64'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_data", rsp_data, 64'd14);
            chk("bp_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_vld", {63'd0, rsp_valid}, 64'd0);
        chk("bp_release_rdy", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
        chk("bp_next_accepted", {63'd0, req_ready}, 64'd0);
        wait_rsp(n, 1'b0, 0, 0, 0);
        chk("bp_next_lat", 64'(n), 64'd1);
        chk("bp_next_data", rsp_data, 64'd2);
        finish_rsp("bp_next");

        // reset in the middle of a div
        issue(2'b11, 64'd50, 64'd5);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        chk("abort_ready", {63'd0, req_ready}, 64'd0);
        chk("abort_valid", {63'd0, rsp_valid}, 64'd0);
        chk("abort_data", rsp_data, 64'd0);
        chk("abort_in1", alu_in1, 64'd0);
        chk("abort_sig", {62'd0, alu_signal}, 64'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 64'(seen), 64'd0);
        issue(2'b00, 64'd3, 64'd4);
        wait_rsp(n, 1'b0, 0, 0, 0);
        chk("after_abort_lat", 64'(n), 64'd1);
        chk("after_abort_data", rsp_data, 64'd7);
        finish_rsp("after_abort");

        // divide by zero
        issue(2'b11, 64'd9, 64'd0);
        wait_rsp(n, 1'b0, 0, 0, 0);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        chk("dz_lat", 64'(n), 64'd1);
        chk("dz_data", rsp_data, ALL_ONES);
        chk("dz_err", {63'd0, rsp_err}, 64'd1);
`else
        chk("dz_lat", 64'(n), 64'd8);
        chk("dz_data", rsp_data, DIV0_VALUE);
        chk("dz_err", {63'd0, rsp_err}, 64'd0);
`endif
        finish_rsp("dz");

        // operand stability while waiting on a mul
        issue(2'b10, 64'd6, 64'd7);
        wait_rsp(n, 1'b1, 64'd6, 64'd7, 2'b10);
        chk("stab_lat", 64'(n), 64'd3);
        chk("stab_data", rsp_data, 64'd42);
        chk("stab_err", {63'd0, rsp_err}, 64'd0);
        finish_rsp("stab");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
